// File: rtl/panzer16_pkg.sv
// Shared widths, types and helpers for the PANZER16 operand-fetch slice.
// The optional R0-reads-as-zero mode is selected by PANZER16_ZERO_R0_EN.
package panzer16_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 4;
  localparam int IDX_W  = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [NREG-1:0]   reg_mask_t;

  // Contents of the single output slot handed to the operand mux / ALU.
  typedef struct packed {
    word_t    op_a;
    word_t    op_b;
    reg_idx_t dst;
    logic     dst_valid;
  } slot_t;

`ifdef PANZER16_ZERO_R0_EN
  localparam reg_mask_t PEND_MASK = reg_mask_t'({NREG{1'b1}} << 1);
`else
  localparam reg_mask_t PEND_MASK = reg_mask_t'({NREG{1'b1}});
`endif

  function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
    return reg_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/panzer16_regfile.sv
// R0-R3 storage: one write port, two combinational read ports with write bypass.
// With PANZER16_ZERO_R0_EN defined, R0 ignores writes and always reads as zero.
module panzer16_regfile
  import panzer16_pkg::*;
(
  input  logic     Clk,
  input  logic     Rst,
  input  logic     i_we,
  input  reg_idx_t i_widx,
  input  word_t    i_wdata,
  input  reg_idx_t i_ra,
  input  reg_idx_t i_rb,
  output word_t    o_rdata_a,
  output word_t    o_rdata_b
);

  word_t     r_regs [NREG];
  reg_mask_t w_wr_sel;
  reg_idx_t  w_ridx  [2];
  word_t     w_rdata [2];

  assign w_wr_sel = (i_we ? idx_onehot(i_widx) : '0) & PEND_MASK;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          r_regs[gi] <= '0;
        end else if (w_wr_sel[gi]) begin
          r_regs[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign w_ridx[0] = i_ra;
  assign w_ridx[1] = i_rb;

  // A same-cycle write is forwarded so the slot never captures a stale value.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      word_t w_byp;
      assign w_byp = (i_we && (i_widx == w_ridx[gi])) ? i_wdata : r_regs[w_ridx[gi]];
`ifdef PANZER16_ZERO_R0_EN
      assign w_rdata[gi] = (w_ridx[gi] == '0) ? '0 : w_byp;
`else
      assign w_rdata[gi] = w_byp;
`endif
    end
  endgenerate

  assign o_rdata_a = w_rdata[0];
  assign o_rdata_b = w_rdata[1];

endmodule

// File: rtl/operand_fetch_stage.sv
// PANZER16 operand fetch: hazard scoreboard, request handshake and 1-deep output slot.
// PANZER16_ZERO_R0_EN turns R0 into a hardwired zero that is never tracked as pending.
module operand_fetch_stage
  import panzer16_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [IDX_W-1:0]  SrcA,
  input  logic [IDX_W-1:0]  SrcB,
  input  logic              DstValid,
  input  logic [IDX_W-1:0]  Dst,
  input  logic              WrEn,
  input  logic [IDX_W-1:0]  WrIdx,
  input  logic [DATA_W-1:0] WrData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [IDX_W-1:0]  OutDst,
  output logic              OutDstValid,
  output logic [NREG-1:0]   Pending
);

  reg_mask_t r_pending;
  slot_t     r_slot;
  logic      r_out_valid;

  word_t     w_byp_a;
  word_t     w_byp_b;
  reg_mask_t w_clear;
  reg_mask_t w_set;
  reg_mask_t w_pend_next;
  logic      w_haz_a;
  logic      w_haz_b;
  logic      w_haz_d;
  logic      w_slot_free;
  logic      w_accept;

  panzer16_regfile u_regfile (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_we      (WrEn),
    .i_widx    (WrIdx),
    .i_wdata   (WrData),
    .i_ra      (SrcA),
    .i_rb      (SrcB),
    .o_rdata_a (w_byp_a),
    .o_rdata_b (w_byp_b)
  );

  assign w_clear = (WrEn ? idx_onehot(WrIdx) : '0) & PEND_MASK;

  // A write landing this cycle resolves its own hazard, so it is not a stall.
  assign w_haz_a = r_pending[SrcA] && !w_clear[SrcA];
  assign w_haz_b = r_pending[SrcB] && !w_clear[SrcB];
  assign w_haz_d = DstValid && r_pending[Dst] && !w_clear[Dst];

  assign w_slot_free = !r_out_valid || OutReady;
  assign ReqReady    = !Rst && !(w_haz_a || w_haz_b || w_haz_d) && w_slot_free;
  assign w_accept    = ReqValid && ReqReady;

  // Set is OR-ed after clear so a same-index set/clear pair leaves the bit set.
  assign w_set       = ((w_accept && DstValid) ? idx_onehot(Dst) : '0) & PEND_MASK;
  assign w_pend_next = ((r_pending & ~w_clear) | w_set) & PEND_MASK;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_out_valid <= 1'b0;
      r_slot      <= '0;
    end else if (w_accept) begin
      r_out_valid      <= 1'b1;
      r_slot.op_a      <= w_byp_a;
      r_slot.op_b      <= w_byp_b;
      r_slot.dst       <= Dst;
      r_slot.dst_valid <= DstValid;
    end else if (r_out_valid && OutReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign OutValid    = r_out_valid;
  assign OpA         = r_slot.op_a;
  assign OpB         = r_slot.op_b;
  assign OutDst      = r_slot.dst;
  assign OutDstValid = r_slot.dst_valid;
  assign Pending     = r_pending;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: a scoreboard queue of expected slots
// is filled by the stimulus and drained by a monitor on every slot hand-off.
module tb_operand_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [1:0]  SrcA = '0;
  logic [1:0]  SrcB = '0;
  logic        DstValid = 1'b0;
  logic [1:0]  Dst = '0;
  logic        WrEn = 1'b0;
  logic [1:0]  WrIdx = '0;
  logic [15:0] WrData = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [1:0]  OutDst;
  logic        OutDstValid;
  logic [3:0]  Pending;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  logic [34:0] exp_q[$];

  operand_fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .SrcA(SrcA), .SrcB(SrcB), .DstValid(DstValid), .Dst(Dst),
    .WrEn(WrEn), .WrIdx(WrIdx), .WrData(WrData),
    .OutValid(OutValid), .OutReady(OutReady), .OpA(OpA), .OpB(OpB),
    .OutDst(OutDst), .OutDstValid(OutDstValid), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: a slot is consumed at the edge after any negedge where it is valid and ready.
  always @(negedge Clk) begin
    if (!Rst && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_slot", {OpA, OpB, OutDst, OutDstValid}, 35'h7_ffff_ffff);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: opa=%h opb=%h dst=%0d dv=%0b (want %h)",
                 txn, OpA, OpB, OutDst, OutDstValid, e);
        chk("slot", {OpA, OpB, OutDst, OutDstValid}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic req(input logic [1:0] a, input logic [1:0] b, input logic dv, input logic [1:0] d);
    ReqValid = 1'b1; SrcA = a; SrcB = b; DstValid = dv; Dst = d;
  endtask

  task automatic wr(input logic [1:0] i, input logic [15:0] dat);
    WrEn = 1'b1; WrIdx = i; WrData = dat;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] d, input logic dv);
    exp_q.push_back({a, b, d, dv});
  endtask

  // End of cycle: advance past the edge and return all strobes to idle.
  task automatic next();
    @(posedge Clk); #1;
    ReqValid = 1'b0; DstValid = 1'b0; WrEn = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst_outvalid", 35'(OutValid), 35'd0);
    chk("rst_pending", 35'(Pending), 35'd0);
    chk("rst_reqready", 35'(ReqReady), 35'd0);
    chk("rst_ops", {OpA, OpB, OutDst, OutDstValid}, 35'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Read after reset
    req(2'd1, 2'd2, 1'b0, 2'd0); push(16'h0, 16'h0, 2'd0, 1'b0);
    @(negedge Clk); chk("rd_ready", 35'(ReqReady), 35'd1);
    next();
    @(negedge Clk); chk("rd_pending", 35'(Pending), 35'd0);
    wr(2'd1, 16'h1111);
    next();

    // Same-cycle write bypass
    wr(2'd2, 16'hBEEF); req(2'd2, 2'd1, 1'b0, 2'd0); push(16'hBEEF, 16'h1111, 2'd0, 1'b0);
    next();

    // RAW / WAW stall on R3
    req(2'd0, 2'd0, 1'b1, 2'd3); push(16'h0, 16'h0, 2'd3, 1'b1);
    next();
    req(2'd0, 2'd0, 1'b1, 2'd3);
    @(negedge Clk);
    chk("raw_pending", 35'(Pending), 35'b1000);
    chk("waw_stall", 35'(ReqReady), 35'd0);
    next();
    req(2'd0, 2'd3, 1'b0, 2'd0);
    @(negedge Clk); chk("raw_stall", 35'(ReqReady), 35'd0);
    next();
    req(2'd0, 2'd3, 1'b0, 2'd0); wr(2'd3, 16'h1234); push(16'h0, 16'h1234, 2'd0, 1'b0);
    @(negedge Clk); chk("raw_release", 35'(ReqReady), 35'd1);
    next();
    @(negedge Clk); chk("raw_cleared", 35'(Pending), 35'd0);
    next();

    // Backpressure: slot held for three cycles
    req(2'd1, 2'd2, 1'b0, 2'd0); push(16'h1111, 16'hBEEF, 2'd0, 1'b0);
    next();
    OutReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req(2'd3, 2'd2, 1'b0, 2'd0);
      @(negedge Clk);
      chk("bp_ready", 35'(ReqReady), 35'd0);
      chk("bp_hold", {OpA, OpB, OutDst, OutDstValid}, {16'h1111, 16'hBEEF, 2'd0, 1'b0});
      next();
    end
    OutReady = 1'b1;
    req(2'd3, 2'd2, 1'b0, 2'd0); push(16'h1234, 16'hBEEF, 2'd0, 1'b0);
    @(negedge Clk); chk("bp_release", 35'(ReqReady), 35'd1);
    next();

    // Set wins over clear on the same index
    req(2'd0, 2'd0, 1'b1, 2'd1); push(16'h0, 16'h0, 2'd1, 1'b1);
    next();
    req(2'd1, 2'd0, 1'b1, 2'd1); wr(2'd1, 16'h5A5A); push(16'h5A5A, 16'h0, 2'd1, 1'b1);
    @(negedge Clk); chk("setwin_ready", 35'(ReqReady), 35'd1);
    next();
    @(negedge Clk); chk("setwin_pending", 35'(Pending), 35'b0010);
    wr(2'd1, 16'h5A5A);
    next();
    req(2'd1, 2'd3, 1'b0, 2'd0); push(16'h5A5A, 16'h1234, 2'd0, 1'b0);
    @(negedge Clk); chk("clr_pending", 35'(Pending), 35'd0);
    next();

    // Asynchronous reset while a slot is held and R1/R2 are pending
    req(2'd2, 2'd1, 1'b1, 2'd1); push(16'hBEEF, 16'h5A5A, 2'd1, 1'b1);
    next();
    req(2'd0, 2'd0, 1'b1, 2'd2);
    next();
    OutReady = 1'b0;
    @(negedge Clk);
    chk("pre_rst_state", {33'd0, OutValid, 1'b0}, {33'd0, 1'b1, 1'b0});
    chk("pre_rst_pending", 35'(Pending), 35'b0110);
    exp_q.delete();
    #2 Rst = 1'b1;
    #1;
    chk("arst_outvalid", 35'(OutValid), 35'd0);
    chk("arst_pending", 35'(Pending), 35'd0);
    @(posedge Clk); #1;
    Rst = 1'b0; OutReady = 1'b1;
    req(2'd1, 2'd2, 1'b0, 2'd0); push(16'h0, 16'h0, 2'd0, 1'b0);
    next();

    // R0 behaviour (hardwired zero only when the option is built in)
    wr(2'd0, 16'hFFFF);
    next();
`ifdef PANZER16_ZERO_R0_EN
    req(2'd0, 2'd0, 1'b1, 2'd0); push(16'h0, 16'h0, 2'd0, 1'b1);
    next();
    @(negedge Clk); chk("r0_pending", 35'(Pending), 35'd0);
`else
    req(2'd0, 2'd0, 1'b1, 2'd0); push(16'hFFFF, 16'hFFFF, 2'd0, 1'b1);
    next();
    @(negedge Clk); chk("r0_pending", 35'(Pending), 35'b0001);
`endif
    next();
    next();
    chk("queue_drained", 35'(exp_q.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Operand-fetch stage of the PANZER16 datapath; sits directly upstream of the 16-bit 4-way operand mux and ALU.
- Holds the four 16-bit general registers R0–R3 and presents them as operands.
- Accepts decoded read requests, checks a pending-write scoreboard for hazards, and registers two operands plus destination tag into a 1-deep output slot with valid/ready handshake.
- Write-back port updates registers and clears scoreboard bits.

Parameters:
DATA_W, 16, operand/register width
NREG, 4, number of general registers
IDX_W, 2, register index width (log2 NREG)

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous, active-high reset
ReqValid  in  1  decoded instruction requests operands
ReqReady  out  1  stage accepts request this cycle
SrcA  in  IDX_W  source register index A
SrcB  in  IDX_W  source register index B
DstValid  in  1  request will later write register Dst
Dst  in  IDX_W  destination register index
WrEn  in  1  write-back strobe
WrIdx  in  IDX_W  write-back register index
WrData  in  DATA_W  write-back data
OutValid  out  1  operand slot holds valid data
OutReady  in  1  downstream consumes slot
OpA  out  DATA_W  operand A
OpB  out  DATA_W  operand B
OutDst  out  IDX_W  registered Dst
OutDstValid  out  1  registered DstValid
Pending  out  NREG  scoreboard, bit i = write to Ri outstanding

Behaviour:
- Clock is Clk, reset is Rst: one clock; reset asynchronous, active-high. Rst clears R0–R3, Pending, OutValid, OpA, OpB, OutDst and OutDstValid to 0. Reset mid-operation drops the held slot and all pending bits; no request is accepted during Rst.
- Bypass value for index i = WrData if WrEn && WrIdx==i, else Ri.
- Pending is cleared this cycle for index i when WrEn && WrIdx==i.
- hazA = Pending[SrcA] && !clearing(SrcA); hazB likewise.
- hazD = DstValid && Pending[Dst] && !clearing(Dst). This is the WAW stall.
- ReqReady = !(hazA|hazB|hazD) && (!OutValid || OutReady). It is combinational and does not depend on ReqValid.
- Accept = ReqValid && ReqReady.
  - On Accept: OpA/OpB <= bypass(SrcA)/bypass(SrcB); OutDst/OutDstValid <= Dst/DstValid; OutValid <= 1.
  - If DstValid, Pending[Dst] <= 1.
  - Latency is one cycle from accept to OutValid.
- Slot retire: OutValid && OutReady && !Accept -> OutValid <= 0. Retire and Accept in the same cycle gives back-to-back throughput of 1 per cycle.
- While OutValid && !OutReady, OpA, OpB, OutDst and OutDstValid hold stable.
- Write-back: WrEn writes Ri <= WrData whether or not Pending[WrIdx] is set. It clears Pending[WrIdx].
- Same cycle, same index, set (Accept with DstValid) and clear (WrEn): set wins, so the bit ends at 1.
- SrcA==SrcB is legal; both operands get the same value. Dst equal to a source is legal.
- WrEn is never stalled.

Optional Feature:
- Macro: PANZER16_ZERO_R0_EN.
- Defined:
  - R0 reads as 0 on both ports and through the bypass.
  - Writes to R0 are ignored.
  - Pending[0] is constant 0 and never causes a hazard.
  - A request with Dst==0 is accepted without setting Pending.
- Undefined: R0 is an ordinary register.

Decomposition:
- Shared package panzer16_pkg holds:
  - DATA_W=16, NREG=4, IDX_W=2;
  - typedefs word_t [15:0] and reg_idx_t [1:0].
- One sub-module, panzer16_regfile: 4x16 storage, one write port, two combinational read ports with write-bypass, and R0 zeroing under the macro.
- Scoreboard, handshake and output slot stay in operand_fetch_stage.

Test Plan:
- Reset then read: Rst pulse; request SrcA=1, SrcB=2 -> next cycle OutValid=1, OpA=0, OpB=0, Pending=0000.
- Write/bypass: write R2=16'hBEEF while a same-cycle request reads SrcA=2 -> OpA=16'hBEEF one cycle later.
- RAW stall: accept Dst=3 (Pending=1000), then request SrcB=3 -> ReqReady=0.
  - On WrEn WrIdx=3 WrData=16'h1234, ReqReady=1 that cycle.
  - Result: OpB=16'h1234 and Pending=0000.
- Backpressure: OutReady=0 for 3 cycles with ReqValid=1 -> ReqReady=0 and OpA/OpB stable. When OutReady goes to 1, the new slot loads next cycle.
- Set-wins: Pending[1]=1; same cycle WrEn WrIdx=1 and accept Dst=1 -> R1 updated, Pending[1]=1.
- Async reset mid-stall: assert Rst between edges while OutValid=1 and Pending=0110 -> immediate OutValid=0 and Pending=0000. Under PANZER16_ZERO_R0_EN, a write of R0=16'hFFFF then read of R0 -> OpA=0.
